pipe_status_stage: RTL and testbench
====================================

Name: pipe_status_stage

Overview:
- Parametrised elastic pipeline stage for the RISC-V pipeline.
- Carries a DATA_WIDTH payload tagged with a 4-bit forwards status (VALID, BUBBLE, fault/trap codes) in a DEPTH-entry in-order buffer.
- Generates the 2-bit backwards status (READY/STALL/JUMP) for the upstream stage from registered state only, so there is no combinational path from downstream to upstream.
- Adds JUMP flush propagation and precise-fault blocking, which a bare status tag does not provide.

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 2, buffer entries; legal values are 2 to 16.
- PROPAGATE_JUMP, 1, when 1 a downstream JUMP is forwarded upstream as a one-cycle JUMP.
- HOLD_AFTER_FAULT, 1, when 1 no new entries are accepted while a fault/trap entry is buffered.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- in_status  input  4  forwards status from upstream.
- in_data  input  DATA_WIDTH  payload from upstream.
- up_status  output  2  backwards status to upstream.
- out_status  output  4  forwards status to downstream.
- out_data  output  DATA_WIDTH  payload to downstream.
- down_status  input  2  backwards status from downstream.
- occupancy  output  $clog2(DEPTH+1)  number of buffered entries.

Behaviour:
- Encodings:
  - Forwards: VALID=0, BUBBLE=1, FETCH_MISALIGNED=2, FETCH_FAULT=3, ILLEGAL_INSTRUCTION=4, LOAD_MISALIGNED=5, LOAD_FAULT=6, STORE_MISALIGNED=7, STORE_FAULT=8, ECALL=9, EBREAK=10.
  - Backwards: READY=0, STALL=1, JUMP=2.
- Input sanitising: in_status 11–15 is stored as ILLEGAL_INSTRUCTION (4). down_status=3 is treated as STALL.
- "Fault entry" means any stored status in the range 2–10.
- Single clock, synchronous active-high reset. A 1 on reset at any edge, including mid-operation, clears the stage:
  - count=0; jump_pending=0; fault_block=0.
  - up_status=READY; out_status=BUBBLE; out_data=0; occupancy=0.
  - Buffered contents are discarded.
- up_status, a pure function of registers, by priority:
  1. JUMP if jump_pending.
  2. STALL if count==DEPTH.
  3. STALL if HOLD_AFTER_FAULT and fault_block.
  4. Otherwise READY.
- Push: occurs at an edge when up_status==READY, in_status!=BUBBLE, and down_status!=JUMP.
  - BUBBLEs are never stored.
  - Upstream must hold in_status/in_data stable while it sees STALL.
- Output:
  - When count>0: out_status/out_data come from the head entry.
  - When count==0: out_status=BUBBLE and out_data=0.
  - Latency from push to visibility at out_* is 1 cycle.
- Pop: occurs at an edge when count>0 and down_status==READY. The head is removed and FIFO order is preserved.
- Simultaneous push and pop (count<DEPTH): count is unchanged, the new entry goes to the tail, and the old head leaves.
- Full buffer: no push is possible because up_status=STALL. A pop while full frees a slot, and up_status returns to READY the following cycle.
- Flush, when down_status==JUMP at an edge:
  - count becomes 0 and the incoming entry is dropped.
  - fault_block clears.
  - jump_pending is set to PROPAGATE_JUMP.
- jump_pending:
  - Clears at the next edge unless another JUMP arrives.
  - While it is set, the input is ignored.
- fault_block:
  - Sets on a push of a fault entry.
  - Clears when that entry is popped, or on a JUMP.
  - Only one fault entry is ever buffered when HOLD_AFTER_FAULT=1.
  - When HOLD_AFTER_FAULT=0, fault entries are treated like VALID.
- Throughput: 1 entry/cycle sustained when down_status stays READY, because DEPTH≥2 keeps count≤1 in steady state.
- occupancy equals count.

Test Plan:
1. Reset, then stream VALID data 0x10, 0x11, 0x12 on consecutive cycles with down READY -> out_* show each value exactly 1 cycle after its push; up_status stays READY; occupancy ≤1.
2. DEPTH=2: push 0xA1 and 0xA2 with down STALL -> occupancy=2 and up_status=STALL. Then hold 0xA3 at the input and release down -> out sequence is A1, A2, A3; no loss or duplication.
3. Push 0xB0 as LOAD_FAULT(6), then VALID 0xB1 -> up_status=STALL until the 0xB0 fault is popped. 0xB1 is accepted the cycle after the pop and appears next.
4. Two entries buffered; down_status=JUMP for 1 cycle while a VALID input is presented -> next cycle occupancy=0, out_status=BUBBLE, and up_status=JUMP for exactly 1 cycle, then READY.
5. in_status=13 with data 0xC0 -> out_status=ILLEGAL_INSTRUCTION(4) with data 0xC0. in_status=BUBBLE -> nothing stored; occupancy unchanged.
6. Assert reset with 2 entries buffered and jump_pending set -> next cycle all outputs at reset values. The first push after reset deasserts appears 1 cycle later.

Source files
------------

// File: rtl/pipe_status_stage.sv
// Elastic pipeline stage: DEPTH-entry in-order buffer of {status, payload} with
// registered-only backwards status, JUMP flush propagation and precise-fault blocking.
module pipe_status_stage #(
    parameter int DATA_WIDTH       = 32,
    parameter int DEPTH            = 2,
    parameter int PROPAGATE_JUMP   = 1,
    parameter int HOLD_AFTER_FAULT = 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [3:0]                   in_status,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [1:0]                   up_status,
    output logic [3:0]                   out_status,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic [1:0]                   down_status,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [3:0] ST_BUBBLE  = 4'd1;
    localparam logic [3:0] ST_ILLEGAL = 4'd4;
    localparam logic [3:0] ST_LAST    = 4'd10;

    localparam logic [1:0] BK_READY = 2'd0;
    localparam logic [1:0] BK_STALL = 2'd1;
    localparam logic [1:0] BK_JUMP  = 2'd2;

    logic [3:0]            status_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem   [DEPTH];

    logic [PTR_W-1:0] head_reg, head_next;
    logic [PTR_W-1:0] tail_reg, tail_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             jump_pending_reg, jump_pending_next;
    logic             fault_block_reg, fault_block_next;

    logic [3:0] in_status_clean;
    logic       down_ready;
    logic       down_jump;
    logic       push;
    logic       pop;
    logic       in_is_fault;
    logic       head_is_fault;

    function automatic logic is_fault(input logic [3:0] s);
        return (s >= 4'd2) && (s <= ST_LAST);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Codes above EBREAK are not meaningful upstream; down_status=3 behaves as STALL.
    assign in_status_clean = (in_status > ST_LAST) ? ST_ILLEGAL : in_status;
    assign down_ready      = (down_status == BK_READY);
    assign down_jump       = (down_status == BK_JUMP);

    always_comb begin
        up_status = BK_READY;
        if (jump_pending_reg)
            up_status = BK_JUMP;
        else if (count_reg == CNT_W'(DEPTH))
            up_status = BK_STALL;
        else if ((HOLD_AFTER_FAULT != 0) && fault_block_reg)
            up_status = BK_STALL;
    end

    assign push          = (up_status == BK_READY) && (in_status != ST_BUBBLE) && !down_jump;
    assign pop           = (count_reg != '0) && down_ready;
    assign in_is_fault   = is_fault(in_status_clean);
    assign head_is_fault = is_fault(status_mem[head_reg]);

    always_comb begin
        head_next         = head_reg;
        tail_next         = tail_reg;
        count_next        = count_reg;
        jump_pending_next = 1'b0;
        fault_block_next  = fault_block_reg;

        if (down_jump) begin
            head_next         = '0;
            tail_next         = '0;
            count_next        = '0;
            jump_pending_next = (PROPAGATE_JUMP != 0);
            fault_block_next  = 1'b0;
        end else begin
            if (push)
                tail_next = ptr_inc(tail_reg);
            if (pop)
                head_next = ptr_inc(head_reg);
            if (push && !pop)
                count_next = count_reg + 1'b1;
            else if (pop && !push)
                count_next = count_reg - 1'b1;

            // With the hold active a fault push can never coincide with a fault pop.
            if (push && in_is_fault && (HOLD_AFTER_FAULT != 0))
                fault_block_next = 1'b1;
            else if (pop && head_is_fault)
                fault_block_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg         <= '0;
            tail_reg         <= '0;
            count_reg        <= '0;
            jump_pending_reg <= 1'b0;
            fault_block_reg  <= 1'b0;
        end else begin
            head_reg         <= head_next;
            tail_reg         <= tail_next;
            count_reg        <= count_next;
            jump_pending_reg <= jump_pending_next;
            fault_block_reg  <= fault_block_next;
        end
    end

    // Storage needs no reset: entries are only visible while count_reg covers them.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            status_mem[tail_reg] <= in_status_clean;
            data_mem[tail_reg]   <= in_data;
        end
    end

    assign out_status = (count_reg != '0) ? status_mem[head_reg] : ST_BUBBLE;
    assign out_data   = (count_reg != '0) ? data_mem[head_reg] : '0;
    assign occupancy  = count_reg;

endmodule

// File: tb/tb_pipe_status_stage.sv
// Directed bench for pipe_status_stage (defaults: DEPTH=2, jump propagation and fault hold on).
module tb_pipe_status_stage;

    logic        clk;
    logic        reset;
    logic [3:0]  in_status;
    logic [31:0] in_data;
    logic [1:0]  up_status;
    logic [3:0]  out_status;
    logic [31:0] out_data;
    logic [1:0]  down_status;
    logic [1:0]  occupancy;

    int checks = 0;
    int errors = 0;

    pipe_status_stage #(
        .DATA_WIDTH(32),
        .DEPTH(2),
        .PROPAGATE_JUMP(1),
        .HOLD_AFTER_FAULT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_status(in_status),
        .in_data(in_data),
        .up_status(up_status),
        .out_status(out_status),
        .out_data(out_data),
        .down_status(down_status),
        .occupancy(occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  ins;
        logic [31:0] ind;
        logic [1:0]  dn;
        logic [1:0]  up;
        logic [3:0]  os;
        logic [31:0] od;
        logic [1:0]  occ;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    // Drive inputs, take one edge, settle 1 time unit past it.
    task automatic step(input logic rst, input logic [3:0] ins, input logic [31:0] ind,
                        input logic [1:0] dn);
        reset       = rst;
        in_status   = ins;
        in_data     = ind;
        down_status = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] up, input logic [3:0] os,
                         input logic [31:0] od, input logic [1:0] occ);
        checks++;
        if (up_status !== up || out_status !== os || out_data !== od || occupancy !== occ) begin
            errors++;
            $display("FAIL %s: got up=%0d out_status=%0d out_data=%h occ=%0d, expected up=%0d out_status=%0d out_data=%h occ=%0d",
                     name, up_status, out_status, out_data, occupancy, up, os, od, occ);
        end else begin
            $display("ok   %s: up=%0d out_status=%0d out_data=%h occ=%0d",
                     name, up_status, out_status, out_data, occupancy);
        end
    endtask

    initial begin
        reset       = 1'b1;
        in_status   = 4'd1;
        in_data     = '0;
        down_status = 2'd0;

        //            rst   ins    ind         dn     up     os     od          occ
        // reset and streaming
        vecs[0]  = '{1'b1, 4'd1,  32'h0,      2'd0,  2'd0,  4'd1,  32'h0,      2'd0};
        vecs[1]  = '{1'b0, 4'd0,  32'h10,     2'd0,  2'd0,  4'd0,  32'h10,     2'd1};
        vecs[2]  = '{1'b0, 4'd0,  32'h11,     2'd0,  2'd0,  4'd0,  32'h11,     2'd1};
        vecs[3]  = '{1'b0, 4'd0,  32'h12,     2'd0,  2'd0,  4'd0,  32'h12,     2'd1};
        vecs[4]  = '{1'b0, 4'd1,  32'h0,      2'd0,  2'd0,  4'd1,  32'h0,      2'd0};
        // fill to DEPTH under STALL, then drain with A3 held at the input
        vecs[5]  = '{1'b0, 4'd0,  32'hA1,     2'd1,  2'd0,  4'd0,  32'hA1,     2'd1};
        vecs[6]  = '{1'b0, 4'd0,  32'hA2,     2'd1,  2'd1,  4'd0,  32'hA1,     2'd2};
        vecs[7]  = '{1'b0, 4'd0,  32'hA3,     2'd1,  2'd1,  4'd0,  32'hA1,     2'd2};
        vecs[8]  = '{1'b0, 4'd0,  32'hA3,     2'd0,  2'd0,  4'd0,  32'hA2,     2'd1};
        vecs[9]  = '{1'b0, 4'd0,  32'hA3,     2'd0,  2'd0,  4'd0,  32'hA3,     2'd1};
        vecs[10] = '{1'b0, 4'd1,  32'h0,      2'd0,  2'd0,  4'd1,  32'h0,      2'd0};
        // status 13 sanitised to ILLEGAL (a fault), bubbles never stored, down=3 acts as STALL
        vecs[11] = '{1'b0, 4'd13, 32'hC0,     2'd1,  2'd1,  4'd4,  32'hC0,     2'd1};
        vecs[12] = '{1'b0, 4'd1,  32'h0,      2'd0,  2'd0,  4'd1,  32'h0,      2'd0};
        vecs[13] = '{1'b0, 4'd0,  32'hD0,     2'd1,  2'd0,  4'd0,  32'hD0,     2'd1};
        vecs[14] = '{1'b0, 4'd1,  32'hDEAD,   2'd3,  2'd0,  4'd0,  32'hD0,     2'd1};
        vecs[15] = '{1'b0, 4'd1,  32'h0,      2'd0,  2'd0,  4'd1,  32'h0,      2'd0};

        for (int i = 0; i < NVEC; i++) begin
            step(vecs[i].rst, vecs[i].ins, vecs[i].ind, vecs[i].dn);
            check($sformatf("vec%0d", i), vecs[i].up, vecs[i].os, vecs[i].od, vecs[i].occ);
        end

        // Precise fault: LOAD_FAULT blocks VALID B1 until popped
        step(1'b0, 4'd6, 32'hB0, 2'd1); check("fault_push",    2'd1, 4'd6, 32'hB0, 2'd1);
        step(1'b0, 4'd0, 32'hB1, 2'd1); check("fault_hold",    2'd1, 4'd6, 32'hB0, 2'd1);
        step(1'b0, 4'd0, 32'hB1, 2'd0); check("fault_pop",     2'd0, 4'd1, 32'h0,  2'd0);
        step(1'b0, 4'd0, 32'hB1, 2'd1); check("after_fault",   2'd0, 4'd0, 32'hB1, 2'd1);
        step(1'b0, 4'd1, 32'h0,  2'd0); check("fault_drain",   2'd0, 4'd1, 32'h0,  2'd0);

        // JUMP flush with two entries and a VALID input presented
        step(1'b0, 4'd0, 32'hE1, 2'd1); check("jmp_fill1",     2'd0, 4'd0, 32'hE1, 2'd1);
        step(1'b0, 4'd0, 32'hE2, 2'd1); check("jmp_fill2",     2'd1, 4'd0, 32'hE1, 2'd2);
        step(1'b0, 4'd0, 32'hE3, 2'd2); check("jmp_flush",     2'd2, 4'd1, 32'h0,  2'd0);
        step(1'b0, 4'd0, 32'hE3, 2'd0); check("jmp_clear",     2'd0, 4'd1, 32'h0,  2'd0);
        step(1'b0, 4'd0, 32'hE3, 2'd1); check("jmp_resume",    2'd0, 4'd0, 32'hE3, 2'd1);
        step(1'b0, 4'd1, 32'h0,  2'd0); check("jmp_drain",     2'd0, 4'd1, 32'h0,  2'd0);

        // Mid-operation reset: full buffer, then with jump_pending set
        step(1'b0, 4'd0, 32'hF1, 2'd1); check("rst_fill1",     2'd0, 4'd0, 32'hF1, 2'd1);
        step(1'b0, 4'd0, 32'hF2, 2'd1); check("rst_fill2",     2'd1, 4'd0, 32'hF1, 2'd2);
        step(1'b1, 4'd0, 32'hF3, 2'd1); check("rst_full",      2'd0, 4'd1, 32'h0,  2'd0);
        step(1'b0, 4'd0, 32'hF3, 2'd2); check("rst_jmp_set",   2'd2, 4'd1, 32'h0,  2'd0);
        step(1'b1, 4'd0, 32'hF3, 2'd2); check("rst_over_jmp",  2'd0, 4'd1, 32'h0,  2'd0);
        step(1'b0, 4'd0, 32'h77, 2'd1); check("rst_first_push",2'd0, 4'd0, 32'h77, 2'd1);
        step(1'b0, 4'd1, 32'h0,  2'd0); check("rst_drain",     2'd0, 4'd1, 32'h0,  2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
